// File: rtl/jtag_shift_engine.sv
// JTAG shift engine: turns TAP_RESET / SHIFT_IR / SHIFT_DR / RUN_IDLE commands into divided TCK/TMS/TDI
// waveforms and captures TDO. Define JTAG_TRSTN_EN to add the active-low trstn TAP reset output.
module jtag_shift_engine #(
  parameter int DATA_W = 64,
  parameter int DIV    = 2,
  localparam int LEN_W = $clog2(DATA_W+1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo,
`ifdef JTAG_TRSTN_EN
  output logic              trstn,
`endif
  output logic              init_done
);
  localparam int CW = $clog2(2*DIV);
  localparam int IW = (LEN_W > 3) ? LEN_W : 3;
  localparam logic [CW-1:0] HI_AT  = CW'(DIV-1);
  localparam logic [CW-1:0] END_AT = CW'(2*DIV-1);
  localparam logic [IW-1:0] ONE    = IW'(1);
  localparam logic [1:0] OP_RST = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2, OP_RUN = 2'd3;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [1:0]        r_op;
  logic [LEN_W-1:0]  r_len;
  logic [DATA_W-1:0] r_sh, r_bit, r_rsp;
  logic              r_from_cmd, r_tck, r_tms, r_tdi;
  logic              r_cmd_ready, r_rsp_valid, r_init_done;
`ifdef JTAG_TRSTN_EN
  logic              r_trstn;
  assign trstn = r_trstn;
`endif

  logic [LEN_W-1:0]  w_len;
  logic [IW-1:0]     w_nidx, w_len_m1, w_pre_last;
  logic              w_is_shift;

  assign w_len      = (cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_len;
  assign w_nidx     = r_idx + ONE;
  assign w_len_m1   = IW'(r_len) - ONE;
  assign w_pre_last = (r_op == OP_IR) ? IW'(3) : IW'(2);
  assign w_is_shift = (r_op == OP_IR) || (r_op == OP_DR);

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp;
  assign tck       = r_tck;
  assign tms       = r_tms;
  assign tdi       = r_tdi;
  assign init_done = r_init_done;

  // Each TCK period: the edge that drops tck also presents that period's TMS/TDI;
  // the period-end edge computes the next bit, so entering a state presents its first bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_op        <= OP_RST;
      r_len       <= '0;
      r_sh        <= '0;
      r_bit       <= '0;
      r_rsp       <= '0;
      r_from_cmd  <= 1'b0;
      r_tck       <= 1'b0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_init_done <= 1'b0;
`ifdef JTAG_TRSTN_EN
      r_trstn     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tck <= 1'b0;
          r_tms <= 1'b0;
          r_tdi <= 1'b0;
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_op        <= cmd_op;
            r_len       <= w_len;
            r_sh        <= (cmd_op == OP_IR || cmd_op == OP_DR) ? cmd_data : '0;
            r_bit       <= DATA_W'(1);
            r_rsp       <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            case (cmd_op)
              OP_RST: begin
                r_state    <= S_INIT;
                r_from_cmd <= 1'b1;
                r_tms      <= 1'b1;
`ifdef JTAG_TRSTN_EN
                r_trstn    <= 1'b0;
`endif
              end
              OP_IR, OP_DR: begin
                if (w_len == '0) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                end else begin
                  r_state <= S_PRE;
                  r_tms   <= 1'b1;
                end
              end
              default: begin
                if (w_len == '0) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                end else begin
                  r_state <= S_SHIFT;
                end
              end
            endcase
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          if (r_cnt == HI_AT) begin
            r_tck <= 1'b1;
            r_cnt <= r_cnt + CW'(1);
            if (r_state == S_SHIFT && w_is_shift && tdo)
              r_rsp <= r_rsp | r_bit;
          end else if (r_cnt == END_AT) begin
            r_tck <= 1'b0;
            r_cnt <= '0;
            r_idx <= w_nidx;
            r_tdi <= 1'b0;
            case (r_state)
              S_INIT: begin
                if (r_idx == IW'(5)) begin
                  r_idx      <= '0;
                  r_tms      <= 1'b0;
                  r_from_cmd <= 1'b0;
                  if (r_from_cmd) begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                  end else begin
                    r_state     <= S_IDLE;
                    r_init_done <= 1'b1;
                    r_cmd_ready <= 1'b1;
                  end
                end else begin
                  r_tms <= (w_nidx < IW'(5));
`ifdef JTAG_TRSTN_EN
                  r_trstn <= (w_nidx == IW'(5));
`endif
                end
              end
              S_PRE: begin
                if (r_idx == w_pre_last) begin
                  r_state <= S_SHIFT;
                  r_idx   <= '0;
                  r_tms   <= (r_len == LEN_W'(1));
                  r_tdi   <= r_sh[0];
                  r_sh    <= r_sh >> 1;
                end else begin
                  r_tms <= (r_op == OP_IR) && (w_nidx == ONE);
                end
              end
              S_SHIFT: begin
                if (r_idx == w_len_m1) begin
                  r_idx <= '0;
                  if (w_is_shift) begin
                    r_state <= S_POST;
                    r_tms   <= 1'b1;
                  end else begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_tms       <= 1'b0;
                  end
                end else begin
                  r_tms <= w_is_shift && (w_nidx == w_len_m1);
                  r_tdi <= r_sh[0];
                  r_sh  <= r_sh >> 1;
                  r_bit <= r_bit << 1;
                end
              end
              S_POST: begin
                r_tms <= 1'b0;
                if (r_idx == ONE) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_idx       <= '0;
                end
              end
              default: ;
            endcase
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_shift_engine.sv
// Bench for jtag_shift_engine: an IEEE 1149.1 TAP model (IR capture 0x01, Shift-DR echoes TDI)
// plus directed and randomized commands checked against op-level expectations.
module tb_jtag_shift_engine;
  localparam int DW   = 64;
  localparam int LW   = $clog2(DW+1);
  localparam int DIVP = 2;
  localparam logic [1:0] OP_RST = 2'd0, OP_IR = 2'd1, OP_DR = 2'd2, OP_RUN = 2'd3;
  localparam int TLR = 0, RTI = 1, SDS = 2, CDR = 3, SDR = 4, E1D = 5, PDR = 6, E2D = 7,
                 UDR = 8, SIS = 9, CIR = 10, SIR = 11, E1I = 12, PIR = 13, E2I = 14, UIR = 15;

  logic clock = 1'b0;
  logic reset, cmd_valid, rsp_ready, cmd_ready, rsp_valid, tck, tms, tdi, tdo, init_done;
  logic [1:0] cmd_op;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_data, rsp_data;
`ifdef JTAG_TRSTN_EN
  logic trstn;
`endif

  int tests = 0;
  int fails = 0;
  int tck_cnt = 0;
  logic tms_q[$];
  int tap = TLR;
  logic [4:0] ir_sr = 5'd0;

  always #5 clock = ~clock;

  jtag_shift_engine #(.DATA_W(DW), .DIV(DIVP)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
`ifdef JTAG_TRSTN_EN
    .trstn(trstn),
`endif
    .init_done(init_done)
  );

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR: return m ? TLR : RTI;
      RTI: return m ? SDS : RTI;
      SDS: return m ? SIS : CDR;
      CDR: return m ? E1D : SDR;
      SDR: return m ? E1D : SDR;
      E1D: return m ? UDR : PDR;
      PDR: return m ? E2D : PDR;
      E2D: return m ? UDR : SDR;
      UDR: return m ? SDS : RTI;
      SIS: return m ? TLR : CIR;
      CIR: return m ? E1I : SIR;
      SIR: return m ? E1I : SIR;
      E1I: return m ? UIR : PIR;
      PIR: return m ? E2I : PIR;
      E2I: return m ? UIR : SIR;
      default: return m ? SDS : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    tck_cnt = tck_cnt + 1;
    tms_q.push_back(tms);
    if (tap == CIR) ir_sr = 5'b00001;
    else if (tap == SIR) ir_sr = {tdi, ir_sr[4:1]};
    tap = tap_next(tap, tms);
  end

  assign tdo = (tap == SDR) ? tdi : (tap == SIR) ? ir_sr[0] : 1'b0;

  // Expected TCK pulses and response per command, from the op definitions.
  function automatic int exp_tcks(input logic [1:0] op, input int len);
    int l = (len > DW) ? DW : len;
    case (op)
      OP_RST: return 6;
      OP_IR:  return (l == 0) ? 0 : 4 + l + 2;
      OP_DR:  return (l == 0) ? 0 : 3 + l + 2;
      default: return l;
    endcase
  endfunction

  function automatic logic [63:0] exp_rsp(input logic [1:0] op, input int len, input logic [63:0] data);
    int l = (len > DW) ? DW : len;
    logic [63:0] mask = (l >= 64) ? ~64'd0 : ((64'd1 << l) - 64'd1);
    logic [68:0] ext = {data, 5'b00001};
    case (op)
      OP_DR:   return data & mask;
      OP_IR:   return ext[63:0] & mask;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] tms_bits(input int base, input int n);
    logic [63:0] r = 64'd0;
    for (int i = 0; i < n && i < 64; i++)
      if (base + i < tms_q.size()) r[i] = tms_q[base + i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input int len, input logic [63:0] data);
    int n = 0;
    @(negedge clock);
    while (!cmd_ready && n < 2000) begin @(negedge clock); n++; end
    check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = LW'(len); cmd_data = data;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 5000) begin @(negedge clock); lat++; end
    check("rsp_valid_wait", 64'(rsp_valid), 64'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
  endtask

  // Called at a negedge with reset high; releases reset and checks the TAP reset sequence.
  task automatic check_init();
    int bt = tck_cnt;
    int bq = tms_q.size();
    int at = 0;
    logic tr_early = 1'b0;
    reset = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (init_done && at == 0) at = i;
`ifdef JTAG_TRSTN_EN
      if (i == 2) tr_early = trstn;
`endif
    end
    check("init_done_clocks", 64'(at), 64'd24);
    check("init_tck_pulses", 64'(tck_cnt - bt), 64'd6);
    check("init_tms_seq", tms_bits(bq, 6), 64'h1F);
    check("init_cmd_ready", 64'(cmd_ready), 64'd1);
    check("init_tap_rti", 64'(tap), 64'(RTI));
    check("init_no_rsp", 64'(rsp_valid), 64'd0);
`ifdef JTAG_TRSTN_EN
    check("init_trstn_low", 64'(tr_early), 64'd0);
    check("init_trstn_high", 64'(trstn), 64'd1);
`else
    check("init_trstn_unused", 64'(tr_early), 64'd0);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bt, bq, len, ok;
    logic [1:0] op;
    logic [63:0] data, got, held;

    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_op = 2'd0; cmd_len = '0; cmd_data = '0;
    repeat (4) @(negedge clock);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    check("rst_init_done", 64'(init_done), 64'd0);
    @(negedge clock);
    check_init();
    @(negedge clock);
    check("idle_pins", {61'd0, tck, tms, tdi}, 64'd0);

    // SHIFT_DR 8 bits of 0xA5 through the echoing DR
    bt = tck_cnt; bq = tms_q.size();
    send(OP_DR, 8, 64'hA5); wait_rsp(lat); got = rsp_data; consume();
    check("dr8_rsp", got, 64'hA5);
    check("dr8_tcks", 64'(tck_cnt - bt), 64'd13);
    check("dr8_tms_seq", tms_bits(bq, 13), 64'hC01);
    check("dr8_tap_rti", 64'(tap), 64'(RTI));

    // SHIFT_IR 5 bits returns the IR capture value
    bt = tck_cnt;
    send(OP_IR, 5, 64'h11); wait_rsp(lat); got = rsp_data; consume();
    check("ir5_rsp", got, 64'h01);
    check("ir5_tcks", 64'(tck_cnt - bt), 64'd11);
    check("ir5_tap_rti", 64'(tap), 64'(RTI));

    // Zero-length shift: no TCK, fast response
    bt = tck_cnt;
    send(OP_DR, 0, 64'hFFFF); wait_rsp(lat); got = rsp_data; consume();
    check("len0_tcks", 64'(tck_cnt - bt), 64'd0);
    check("len0_latency", 64'(lat <= 2), 64'd1);
    check("len0_rsp", got, 64'd0);

    // Over-long length clamps to DW shift bits
    data = {$urandom, $urandom};
    bt = tck_cnt;
    send(OP_DR, DW + 5, data); wait_rsp(lat); got = rsp_data; consume();
    check("clamp_tcks", 64'(tck_cnt - bt), 64'(3 + DW + 2));
    check("clamp_rsp", got, data);

    // RUN_IDLE and TAP_RESET
    bt = tck_cnt; bq = tms_q.size();
    send(OP_RUN, 7, 64'hFF); wait_rsp(lat); got = rsp_data; consume();
    check("run_tcks", 64'(tck_cnt - bt), 64'd7);
    check("run_tms", tms_bits(bq, 7), 64'd0);
    check("run_rsp", got, 64'd0);
    bt = tck_cnt; bq = tms_q.size();
    send(OP_RST, 3, 64'h5); wait_rsp(lat); got = rsp_data; consume();
    check("tapreset_tcks", 64'(tck_cnt - bt), 64'd6);
    check("tapreset_tms", tms_bits(bq, 6), 64'h1F);
    check("tapreset_rsp", got, 64'd0);
    check("tapreset_init_done", 64'(init_done), 64'd1);

    // Response back-pressure with a pending command
    data = {$urandom, $urandom};
    send(OP_DR, 8, data); wait_rsp(lat); held = rsp_data;
    bt = tck_cnt; ok = 1;
    cmd_valid = 1'b1; cmd_op = OP_DR; cmd_len = LW'(8);
    repeat (100) begin
      @(negedge clock);
      if (!(rsp_valid === 1'b1 && rsp_data === held && cmd_ready === 1'b0)) ok = 0;
    end
    cmd_valid = 1'b0;
    check("hold_stable", 64'(ok), 64'd1);
    check("hold_no_accept", 64'(tck_cnt - bt), 64'd0);
    check("hold_data", held, data & 64'hFF);
    consume();
    repeat (3) @(negedge clock);
    check("hold_released_idle", {62'd0, cmd_ready, rsp_valid}, 64'd2);

    // Randomized commands against the op-level model
    for (int k = 0; k < 12; k++) begin
      op   = 2'($urandom_range(0, 3));
      len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DW + 5)) : int'($urandom_range(0, 12));
      data = {$urandom, $urandom};
      bt = tck_cnt;
      send(op, len, data); wait_rsp(lat); got = rsp_data; consume();
      check("rand_rsp", got, exp_rsp(op, len, data));
      check("rand_tcks", 64'(tck_cnt - bt), 64'(exp_tcks(op, len)));
      check("rand_tap_rti", 64'(tap), 64'(RTI));
    end

    // Reset in the middle of a shift
    bt = tck_cnt;
    send(OP_DR, 40, {$urandom, $urandom});
    lat = 0;
    while ((tck_cnt - bt) < 10 && lat < 2000) begin @(negedge clock); lat++; end
    check("midshift_reached", 64'((tck_cnt - bt) >= 10), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_pins", {61'd0, tck, tms, tdi}, 64'd2);
    check("midrst_handshake", {62'd0, cmd_ready, rsp_valid}, 64'd0);
    check("midrst_rsp_data", rsp_data, 64'd0);
    check("midrst_init_done", 64'(init_done), 64'd0);
    @(negedge clock);
    check_init();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
